// File: rtl/elevator_call_registry.sv
// Call registry for a 4-floor elevator: synchronises and edge-detects buttons, latches calls
// until served, and drives F/U/D/S. Define CALL_CANCEL_EN to let a repeat car press cancel a call.
module elevator_call_registry #(
  parameter int SYNC_STAGES = 2,
  parameter int CLR_CYCLES  = 2
) (
  input  logic       clk,
  input  logic       reset,
  input  logic [3:0] btn_car,
  input  logic [3:0] btn_up,
  input  logic [3:0] btn_down,
  input  logic [1:0] AC,
  input  logic [2:0] DISP,
  input  logic       open,
  output logic [3:0] F,
  output logic [3:0] U,
  output logic [3:0] D,
  output logic [3:0] S
);
  typedef enum logic {DIR_UP = 1'b0, DIR_DOWN = 1'b1} dir_t;

  localparam logic [2:0]  PRIME_DONE = 3'(SYNC_STAGES + 1);
  localparam logic [3:0]  CLR_MAX    = 4'(CLR_CYCLES);
  // {down[3:0], up[3:0], car[3:0]}; up[3] and down[0] are not real buttons
  localparam logic [11:0] BTN_MASK   = 12'b1110_0111_1111;

  function automatic logic [3:0] sat_inc(input logic [3:0] c);
    return (c >= CLR_MAX) ? CLR_MAX : c + 4'd1;
  endfunction

  function automatic logic [3:0] stop_qualify(input logic [3:0] f,
                                              input logic [3:0] u,
                                              input logic [3:0] d,
                                              input logic       going_up);
    logic [3:0] calls;
    logic [3:0] s;
    logic       beyond;
    calls = f | u | d;
    s     = '0;
    for (int i = 0; i < 4; i++) begin
      beyond = 1'b0;
      for (int j = 0; j < 4; j++)
        if ((going_up && j > i) || (!going_up && j < i)) beyond = beyond | calls[j];
      // a hall call with nothing further along the run is picked up regardless of its direction
      s[i] = f[i] | (u[i] & going_up) | (d[i] & ~going_up) | ((u[i] | d[i]) & ~beyond);
    end
    return s;
  endfunction

  logic [11:0] btn_raw;
  logic [11:0] sync_p0 [SYNC_STAGES];
  logic [11:0] hist_p0;
  logic [2:0]  prime_cnt;
  logic        vld_p0;
  logic [11:0] press_p1;

  assign btn_raw = {btn_down, btn_up, btn_car};
  assign vld_p0  = (prime_cnt == PRIME_DONE);

  // ---- stage p0: synchroniser chain and edge detect; p1: registered press pulse ----
  // Edge detect stays disarmed until the chain has refilled, so buttons held through reset are not seen as presses.
  always_ff @(posedge clk) begin
    if (reset) begin
      for (int k = 0; k < SYNC_STAGES; k++) sync_p0[k] <= '0;
      hist_p0   <= '0;
      prime_cnt <= '0;
      press_p1  <= '0;
    end else begin
      sync_p0[0] <= btn_raw;
      for (int k = 1; k < SYNC_STAGES; k++) sync_p0[k] <= sync_p0[k-1];
      hist_p0 <= sync_p0[SYNC_STAGES-1];
      if (!vld_p0) prime_cnt <= prime_cnt + 3'd1;
      press_p1 <= vld_p0 ? (sync_p0[SYNC_STAGES-1] & ~hist_p0 & BTN_MASK) : '0;
    end
  end

  logic       disp_ok;
  logic       restart;
  logic       clr_fire;
  logic [2:0] disp_q;
  logic [3:0] clr_cnt;
  logic [3:0] clr_cnt_nxt;
  logic [3:0] floor_oh;
  logic [3:0] clr_mask;
  logic [3:0] ign_mask;
  logic [3:0] car_pr;
  logic [3:0] up_pr;
  logic [3:0] dn_pr;
  logic [3:0] f_nxt;
  logic [3:0] u_nxt;
  logic [3:0] d_nxt;
  dir_t       last_dir;
  dir_t       dir_nxt;

  // ---- stage p2: call latches, service clear, direction and stop-qualify ----
  always_comb begin
    disp_ok     = ~DISP[2];
    floor_oh    = 4'b0001 << DISP[1:0];
    restart     = (DISP != disp_q);
    clr_cnt_nxt = '0;
    if (open && disp_ok) clr_cnt_nxt = restart ? 4'd1 : sat_inc(clr_cnt);
    // one-shot: fire only on the transition into CLR_MAX, or on a fresh floor when CLR_MAX is 1
    clr_fire = (clr_cnt_nxt == CLR_MAX) && (restart || (clr_cnt != CLR_MAX));
    clr_mask = clr_fire ? floor_oh : '0;
    ign_mask = (open && disp_ok) ? floor_oh : '0;

    car_pr = press_p1[3:0]  & ~ign_mask;
    up_pr  = press_p1[7:4]  & ~ign_mask;
    dn_pr  = press_p1[11:8] & ~ign_mask;

`ifdef CALL_CANCEL_EN
    f_nxt = (F ^ car_pr) & ~clr_mask;
`else
    f_nxt = (F | car_pr) & ~clr_mask;
`endif
    u_nxt = (U | up_pr) & ~clr_mask & 4'b0111;
    d_nxt = (D | dn_pr) & ~clr_mask & 4'b1110;

    dir_nxt = last_dir;
    if (AC == 2'd1)  dir_nxt = DIR_UP;
    else if (AC[1])  dir_nxt = DIR_DOWN;
  end

  always_ff @(posedge clk) begin
    disp_q <= DISP;
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      F        <= '0;
      U        <= '0;
      D        <= '0;
      S        <= '0;
      clr_cnt  <= '0;
      last_dir <= DIR_UP;
    end else begin
      F        <= f_nxt;
      U        <= u_nxt;
      D        <= d_nxt;
      S        <= stop_qualify(f_nxt, u_nxt, d_nxt, dir_nxt == DIR_UP);
      clr_cnt  <= clr_cnt_nxt;
      last_dir <= dir_nxt;
    end
  end

endmodule

// File: tb/tb_elevator_call_registry.sv
// Bench for elevator_call_registry: directed scenarios then random traffic, all checked
// against a behavioural model of calls, floor-dwell runs and stop qualification.
module tb_elevator_call_registry;
  localparam int SYNC = 2;
  localparam int CLR  = 2;
`ifdef CALL_CANCEL_EN
  localparam bit CANCEL = 1'b1;
`else
  localparam bit CANCEL = 1'b0;
`endif

  logic        clk = 1'b0;
  logic        reset;
  logic [11:0] btn;
  logic [1:0]  AC;
  logic [2:0]  DISP;
  logic        open;
  logic [3:0]  F, U, D, S;

  elevator_call_registry #(.SYNC_STAGES(SYNC), .CLR_CYCLES(CLR)) dut (
    .clk(clk), .reset(reset),
    .btn_car(btn[3:0]), .btn_up(btn[7:4]), .btn_down(btn[11:8]),
    .AC(AC), .DISP(DISP), .open(open),
    .F(F), .U(U), .D(D), .S(S)
  );

  always #5 clk = ~clk;

  int n_cmp = 0;
  int n_bad = 0;

  logic [3:0]  m_f, m_u, m_d, m_s;
  bit          m_up;
  int          m_run;
  int          m_prev_disp;
  logic [11:0] samp [$];

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_cmp++;
    if (obs !== exp) begin
      n_bad++;
      $display("FAIL %s: got %0h expected %0h at %0t", tag, obs, exp, $time);
    end
  endtask

  // Advance the model by one clock edge using the inputs currently driven.
  task automatic model_edge();
    logic [11:0] press;
    bit          valid;
    int          clr_floor, ign_floor;
    bit          above, below, beyond;
    if (reset) begin
      m_f = 0; m_u = 0; m_d = 0; m_s = 0; m_up = 1; m_run = 0;
      samp.delete();
      return;
    end
    // a press is a 0->1 step of the sampled level, seen SYNC+2 edges after it is first sampled high
    samp.push_back(btn);
    if (samp.size() > SYNC + 3) void'(samp.pop_front());
    press = '0;
    if (samp.size() == SYNC + 3) press = samp[1] & ~samp[0];

    valid = open && (DISP <= 3);
    if (!valid) m_run = 0;
    else if (m_run > 0 && int'(DISP) == m_prev_disp) m_run++;
    else m_run = 1;
    m_prev_disp = int'(DISP);
    clr_floor = (valid && m_run == CLR) ? int'(DISP) : -1;
    ign_floor = valid ? int'(DISP) : -1;

    for (int i = 0; i < 4; i++) begin
      if (i != ign_floor) begin
        if (press[i]) m_f[i] = CANCEL ? ~m_f[i] : 1'b1;
        if (press[4+i] && i != 3) m_u[i] = 1'b1;
        if (press[8+i] && i != 0) m_d[i] = 1'b1;
      end
      if (i == clr_floor) begin
        m_f[i] = 0; m_u[i] = 0; m_d[i] = 0;
      end
    end
    if (AC == 1) m_up = 1;
    else if (AC >= 2) m_up = 0;

    for (int i = 0; i < 4; i++) begin
      above = 0; below = 0;
      for (int j = 0; j < 4; j++) begin
        if (j > i && (m_f[j] || m_u[j] || m_d[j])) above = 1;
        if (j < i && (m_f[j] || m_u[j] || m_d[j])) below = 1;
      end
      beyond = m_up ? above : below;
      m_s[i] = m_f[i] || (m_u[i] && m_up) || (m_d[i] && !m_up) || ((m_u[i] || m_d[i]) && !beyond);
    end
  endtask

  task automatic step(input int n = 1);
    for (int k = 0; k < n; k++) begin
      model_edge();
      @(posedge clk);
      @(negedge clk);
      chk("F", F, m_f);
      chk("U", U, m_u);
      chk("D", D, m_d);
      chk("S", S, m_s);
    end
  endtask

  task automatic press_btn(input logic [11:0] b);
    btn = btn | b;
    step(2);
    btn = btn & ~b;
    step(SYNC + 2);
  endtask

  task automatic dwell(input logic [2:0] floor);
    DISP = floor;
    open = 1;
    step(CLR);
    open = 0;
    step(1);
  endtask

  initial begin
    reset = 1; btn = '0; AC = 0; DISP = 0; open = 0;
    step(2);
    chk("rst_F", F, 4'b0000);
    chk("rst_S", S, 4'b0000);
    reset = 0;
    step(SYNC + 3);

    // car call latency and stop
    press_btn(12'h004);
    chk("t1_F", F, 4'b0100);
    chk("t1_S", S, 4'b0100);

    // hall call cleared after CLR_CYCLES of open at its floor
    press_btn(12'h020);
    chk("t2_U_set", U, 4'b0010);
    DISP = 1; open = 1;
    step(CLR - 1);
    chk("t2_U_held", U, 4'b0010);
    step(1);
    chk("t2_U_clr", U, 4'b0000);
    open = 0;
    step(1);
    chk("t2_S1", S[1], 1'b0);
    dwell(3'd2);

    // direction-qualified stop and end-of-run pickup
    AC = 1;
    press_btn(12'h408);
    chk("t3_F", F, 4'b1000);
    chk("t3_D", D, 4'b0100);
    chk("t3_S", S, 4'b1000);
    dwell(3'd3);
    chk("t3_F_clr", F, 4'b0000);
    chk("t3_S_pick", S, 4'b0100);

    // press at the open floor is ignored; accepted once the door closes
    DISP = 1; open = 1;
    press_btn(12'h020);
    chk("t4_U_ign", U, 4'b0000);
    open = 0;
    step(2);
    press_btn(12'h020);
    chk("t4_U_set", U, 4'b0010);

    // non-existent hall buttons, repeated car press
    press_btn(12'h180);
    chk("t5_U3", U[3], 1'b0);
    chk("t5_D0", D[0], 1'b0);
    chk("t5_U", U, 4'b0010);
    press_btn(12'h001);
    press_btn(12'h001);
    chk("t5_F0", F[0], !CANCEL);

    // reset while a button is held
    btn = 12'h00A;
    step(2);
    btn = 12'h002;
    step(SYNC + 2);
    chk("t6_pre", F & 4'b1010, 4'b1010);
    reset = 1;
    step(1);
    reset = 0;
    chk("t6_F_rst", F, 4'b0000);
    chk("t6_U_rst", U, 4'b0000);
    chk("t6_D_rst", D, 4'b0000);
    step(SYNC + 6);
    chk("t6_F_held", F, 4'b0000);
    btn = '0;
    step(2);
    press_btn(12'h002);
    chk("t6_F_again", F, 4'b0010);

    // random traffic
    for (int c = 0; c < 4000; c++) begin
      if ($urandom_range(0, 7) == 0) btn[$urandom_range(0, 11)] ^= 1'b1;
      if ($urandom_range(0, 5) == 0) open = ~open;
      if ($urandom_range(0, 9) == 0)
        DISP = ($urandom_range(0, 15) == 0) ? 3'($urandom_range(4, 7)) : 3'($urandom_range(0, 3));
      if ($urandom_range(0, 4) == 0) AC = 2'($urandom_range(0, 3));
      reset = ($urandom_range(0, 299) == 0);
      step(1);
    end

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end

endmodule
